// File: rtl/seg_pkg.sv
// Shared segment types and constants for the seven-segment scan controller.
package seg_pkg;

  typedef logic [7:0] seg_t;

  // Bit positions inside a segment vector {dp,g,f,e,d,c,b,a}.
  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam seg_t SEG_BLANK = 8'hFF;

endpackage

// File: rtl/hex_to_7seg.sv
// Hex nibble to active-high segment pattern {g,f,e,d,c,b,a}; purely combinational.
module hex_to_7seg (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h00;
    unique case (nibble)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = 7'h00;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed N-digit common-anode display driver with PWM dimming, anti-ghost gap and
// frame-synchronous double buffering; outputs registered (1 cycle). SEG_LZB_EN adds leading-zero blanking.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 20000,
  parameter int BRIGHT_W   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [BRIGHT_W-1:0]     brightness,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   LEDSEL,
  output logic [7:0]              LEDOUT,
  output logic                    frame_tick
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] PCNT_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]   pcnt_q, pcnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [BRIGHT_W-1:0] pwm_q, pwm_d;
  logic            pending_q, pending_d;
  logic [NUM_DIGITS-1:0][3:0] sh_val_q, sh_val_d, act_val_q, act_val_d;
  logic [NUM_DIGITS-1:0] sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0] sh_en_q, sh_en_d, act_en_q, act_en_d;
  logic [NUM_DIGITS-1:0] ledsel_q, ledsel_d;
  seg_t            ledout_q, ledout_d;
  logic            frame_tick_q, frame_tick_d;

  logic            pcnt_tc, frame_end, pwm_open, seg_on;
  logic [3:0]      cur_nib;
  logic [6:0]      cur_seg;
  seg_t            seg_pat;

  assign pcnt_tc   = (pcnt_q == PCNT_LAST);
  assign frame_end = pcnt_tc && (idx_q == IDX_LAST);
  assign cur_nib   = act_val_q[idx_q];

  hex_to_7seg u_dec (
    .nibble (cur_nib),
    .seg    (cur_seg)
  );

`ifdef SEG_LZB_EN
  logic [NUM_DIGITS-1:0] lz_blank;
  logic                  lz_run;

  // A digit is blanked while every nibble from the top down to it is zero; digit 0 always shows.
  always_comb begin
    lz_blank = '0;
    lz_run   = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      lz_run      = lz_run && (act_val_q[i] == 4'h0);
      lz_blank[i] = lz_run;
    end
  end
`endif

  always_comb begin
    pcnt_d = pcnt_tc ? '0 : pcnt_q + 1'b1;
    idx_d  = idx_q;
    if (pcnt_tc) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    pwm_d  = pwm_q + 1'b1;

    sh_val_d  = sh_val_q;
    sh_dp_d   = sh_dp_q;
    sh_en_d   = sh_en_q;
    act_val_d = act_val_q;
    act_dp_d  = act_dp_q;
    act_en_d  = act_en_q;
    pending_d = pending_q;

    // Transfer uses the shadow as it stood before this cycle; a coincident load re-arms pending.
    if (frame_end && pending_q) begin
      act_val_d = sh_val_q;
      act_dp_d  = sh_dp_q;
      act_en_d  = sh_en_q;
      pending_d = 1'b0;
    end
    if (load) begin
      sh_val_d  = value;
      sh_dp_d   = dp;
      sh_en_d   = digit_en;
      pending_d = 1'b1;
    end
  end

  always_comb begin
    pwm_open = (brightness == '1) || (pwm_q < brightness);
    seg_on   = act_en_q[idx_q] && (pcnt_q != '0) && pwm_open;
    seg_pat          = '0;
    seg_pat[6:0]     = cur_seg;
    seg_pat[SEG_DP]  = act_dp_q[idx_q];
`ifdef SEG_LZB_EN
    if (lz_blank[idx_q]) begin
      seg_on       = seg_on && act_dp_q[idx_q];
      seg_pat[6:0] = 7'h00;
    end
`endif
    ledsel_d     = '1;
    ledout_d     = SEG_BLANK;
    if (seg_on) begin
      ledsel_d[idx_q] = 1'b0;
      ledout_d        = ~seg_pat;
    end
    frame_tick_d = frame_end;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pcnt_q       <= '0;
      idx_q        <= '0;
      pwm_q        <= '0;
      pending_q    <= 1'b0;
      sh_val_q     <= '0;
      sh_dp_q      <= '0;
      sh_en_q      <= '0;
      act_val_q    <= '0;
      act_dp_q     <= '0;
      act_en_q     <= '0;
      ledsel_q     <= '1;
      ledout_q     <= SEG_BLANK;
      frame_tick_q <= 1'b0;
    end else begin
      pcnt_q       <= pcnt_d;
      idx_q        <= idx_d;
      pwm_q        <= pwm_d;
      pending_q    <= pending_d;
      sh_val_q     <= sh_val_d;
      sh_dp_q      <= sh_dp_d;
      sh_en_q      <= sh_en_d;
      act_val_q    <= act_val_d;
      act_dp_q     <= act_dp_d;
      act_en_q     <= act_en_d;
      ledsel_q     <= ledsel_d;
      ledout_q     <= ledout_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign LEDSEL     = ledsel_q;
  assign LEDOUT     = ledout_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomised bench for seg_scan_ctrl against a cycle-count based display model.
module tb_seg_scan_ctrl;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int FR = ND * SD;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp, digit_en, brightness;
  logic        load;
  logic [3:0]  LEDSEL;
  logic [7:0]  LEDOUT;
  logic        frame_tick;

  seg_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BRIGHT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .dp         (dp),
    .digit_en   (digit_en),
    .brightness (brightness),
    .load       (load),
    .LEDSEL     (LEDSEL),
    .LEDOUT     (LEDOUT),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  // Active-high {g..a} glyphs for 0..F.
  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int n_cmp = 0;
  int n_bad = 0;
  int n     = 0;   // edges since reset release

  int          lg_cyc [$];
  logic [15:0] lg_val [$];
  logic [3:0]  lg_dp  [$];
  logic [3:0]  lg_en  [$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @edge %0d: got %0h, expected %0h", tag, n, act, exp);
    end
  endtask

  // One clock edge: log a load, then predict and check what the edge produced.
  task automatic step();
    logic        rst_s;
    logic [3:0]  br_s, exp_sel;
    logic [7:0]  exp_out, pat;
    logic        exp_ft, on, d, e, blank;
    logic [15:0] av;
    logic [3:0]  ad, ae, nib;
    int pc, id, pw, f;
    rst_s = rst;
    br_s  = brightness;
    if (rst && load) begin
      lg_cyc.push_back(n);
      lg_val.push_back(value);
      lg_dp.push_back(dp);
      lg_en.push_back(digit_en);
    end
    @(posedge clk);
    #1;
    exp_sel = 4'hF;
    exp_out = 8'hFF;
    exp_ft  = 1'b0;
    if (!rst_s) begin
      n = 0;
      lg_cyc.delete(); lg_val.delete(); lg_dp.delete(); lg_en.delete();
    end else begin
      pc = n % SD;
      id = (n / SD) % ND;
      pw = n % 16;
      exp_ft = (pc == SD - 1) && (id == ND - 1);
      av = '0; ad = '0; ae = '0;
      // Active data = newest load strictly before the most recent frame boundary.
      if (n >= FR) begin
        f = n - 1 - ((n - FR) % FR);
        for (int i = lg_cyc.size() - 1; i >= 0; i--) begin
          if (lg_cyc[i] < f) begin
            av = lg_val[i]; ad = lg_dp[i]; ae = lg_en[i];
            break;
          end
        end
      end
      nib = av[id*4 +: 4];
      d   = ad[id];
      e   = ae[id];
      on  = e && (pc != 0) && ((br_s == 4'hF) || (pw < int'(br_s)));
      pat = {d, glyph[nib]};
      blank = 1'b0;
`ifdef SEG_LZB_EN
      blank = (id > 0);
      for (int j = id; j < ND; j++) if (av[j*4 +: 4] != 4'h0) blank = 1'b0;
`endif
      if (blank) begin
        on  = on && d;
        pat = {d, 7'h00};
      end
      if (on) begin
        exp_sel = ~(4'b0001 << id);
        exp_out = ~pat;
      end
      n++;
    end
    chk("LEDSEL", 32'(LEDSEL), 32'(exp_sel));
    chk("LEDOUT", 32'(LEDOUT), 32'(exp_out));
    chk("frame_tick", 32'(frame_tick), 32'(exp_ft));
  endtask

  task automatic run_to(input int phase);
    for (int k = 0; k < 2 * FR && (n % FR) != phase; k++) step();
  endtask

  initial begin
    int seen5, on_cnt;
    rst = 1'b0; load = 1'b0; value = '0; dp = '0; digit_en = '0; brightness = 4'hF;
    repeat (3) step();
    rst = 1'b1;

    // Basic scan of 12AB.
    value = 16'h12AB; dp = 4'h0; digit_en = 4'hF; load = 1'b1;
    step();
    load = 1'b0;
    repeat (3 * FR) step();

    // Back-to-back loads: only the last survives.
    run_to(5);
    value = 16'h5555; load = 1'b1; step();
    value = 16'h0007; step();
    load = 1'b0;
    seen5 = 0;
    for (int k = 0; k < 3 * FR; k++) begin
      step();
      if (LEDSEL != 4'hF && LEDOUT == 8'h92) seen5++;
    end
    chk("no_5555", 32'(seen5), 32'd0);

    // Load on the frame_tick edge defers by one frame.
    run_to(FR - 1);
    value = 16'hBEEF; dp = 4'b0101; load = 1'b1; step();
    load = 1'b0;
    repeat (2 * FR) step();

    // Dimming.
    brightness = 4'h4;
    repeat (2 * FR) step();
    brightness = 4'h0;
    on_cnt = 0;
    for (int k = 0; k < 2 * FR; k++) begin
      step();
      if (LEDSEL != 4'hF) on_cnt++;
    end
    chk("bright0_dark", 32'(on_cnt), 32'd0);
    brightness = 4'hF;

    // Leading zeros with a dp on the top digit.
    value = 16'h0040; dp = 4'b1000; digit_en = 4'hF; load = 1'b1; step();
    load = 1'b0;
    repeat (3 * FR) step();

    // Reset with a pending load discards it.
    run_to(7);
    value = 16'h9999; dp = 4'hF; load = 1'b1; step();
    load = 1'b0;
    rst = 1'b0; step();
    chk("rst_ledsel", 32'(LEDSEL), 32'h0F);
    chk("rst_ledout", 32'(LEDOUT), 32'hFF);
    rst = 1'b1;
    on_cnt = 0;
    for (int k = 0; k < 3 * FR; k++) begin
      step();
      if (LEDSEL != 4'hF) on_cnt++;
    end
    chk("pending_dropped", 32'(on_cnt), 32'd0);

    // Random traffic.
    for (int k = 0; k < 2000; k++) begin
      load = ($urandom_range(0, 15) == 0);
      value = $urandom() & {{4{$urandom_range(0, 1) == 1'b1}}, 12'hFFF};
      if ($urandom_range(0, 2) == 0) value[11:4] = 8'h00;
      dp = 4'($urandom());
      digit_en = ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'hF;
      if ($urandom_range(0, 49) == 0)
        brightness = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom());
      rst = ($urandom_range(0, 499) != 0);
      step();
    end
    rst = 1'b1;
    load = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Parametrised, time-multiplexed seven-segment display controller for the board top. It drives N common-anode digits from a hex value with per-digit decimal points and an enable mask. It adds PWM brightness control, anti-ghost blanking, and frame-synchronous double-buffered loading, none of which the fixed 4-digit scan path provides. It sits between the SoC GPO registers and the board LEDSEL/LEDOUT pins, clocked by the system clock.

## Interface
- NUM_DIGITS, 4, number of multiplexed digits (2..8)
- SCAN_DIV, 20000, clock cycles per digit slot (≥ 4)
- BRIGHT_W, 4, brightness control width
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-low reset (asserted when 0)
- value  in  4*NUM_DIGITS  hex nibbles; nibble i → digit i (digit 0 = least significant)
- dp  in  NUM_DIGITS  decimal point per digit, 1 = lit
- digit_en  in  NUM_DIGITS  per-digit enable mask, 0 = digit dark
- brightness  in  BRIGHT_W  duty level; 0 = off, all-ones = fully on
- load  in  1  one-cycle strobe; captures value/dp/digit_en into shadow
- LEDSEL  out  NUM_DIGITS  digit anodes, active-low one-hot
- LEDOUT  out  8  segments {dp,g,f,e,d,c,b,a}, active-low
- frame_tick  out  1  one-cycle pulse on the last cycle of each full scan

## Operation
- Prescaler pcnt counts 0..SCAN_DIV-1 and wraps. Digit index idx advances on pcnt terminal count and wraps NUM_DIGITS-1 → 0.
- frame_tick = 1 in the cycle where pcnt == SCAN_DIV-1 and idx == NUM_DIGITS-1.
- Double buffer:
  - load copies value/dp/digit_en into shadow registers and sets pending.
  - On the frame_tick cycle, if pending: active ← shadow, pending ← 0.
  - A load coinciding with frame_tick updates shadow only. The active transfer in that cycle uses the old shadow; pending stays set and the new data applies at the next frame.
  - Back-to-back loads: last one wins.
- Digit drive for slot idx:
  - Segment pattern = hex decode of active nibble idx, OR dp bit into bit 7, then inverted to active-low.
  - Anode on only when all of the following hold: active digit_en[idx] = 1; pcnt ≠ 0 (one-cycle anti-ghost gap each slot); PWM gate open.
  - Anode off → LEDSEL all ones and LEDOUT = 8'hFF.
- PWM:
  - Free-running counter pwm of BRIGHT_W bits, incremented every clock.
  - Gate open when pwm < brightness, or when brightness is all-ones (forced fully on).
  - brightness = 0 → display dark.
  - brightness is not double-buffered; changes take effect on the next cycle.
- Reset (rst = 0 at a clock edge): pcnt, idx, pwm, pending, and shadow/active registers → 0. LEDSEL → all ones, LEDOUT → 8'hFF, frame_tick → 0. Reset mid-scan discards any pending load.

## Timing
- LEDSEL, LEDOUT, and frame_tick are registered. They reflect idx/pcnt/pwm state from the previous cycle (1-cycle latency).
- Digit slot = SCAN_DIV cycles; full frame = NUM_DIGITS*SCAN_DIV cycles.
- Load-to-display latency is at most 2 frames + 1 cycle.
- The first cycle after reset release shows all outputs dark.

## Configuration
- SEG_LZB_EN defined: leading-zero blanking is active.
  - Scanning from digit NUM_DIGITS-1 downward, every active nibble equal to 0 up to the first non-zero nibble is blanked (LEDOUT = 8'hFF, anode off).
  - Digit 0 is never blanked.
  - A blanked digit still shows its dp if dp is set: anode on, LEDOUT = 8'h7F.
- SEG_LZB_EN undefined: all enabled digits are displayed, including leading zeros. The blanking logic is not compiled in.

## Structure
- Package seg_pkg holds:
  - SEG_BLANK = 8'hFF;
  - the segment bit-order constants;
  - the typedef for the 8-bit segment vector.
- Reuse the existing hex_to_7seg as the single sub-module, instantiated once on the muxed active nibble.
- The leading-zero mask is combinational from active value.

## Test plan
- Reset release, NUM_DIGITS=4, SCAN_DIV=4, brightness=4'hF, load value=16'h12AB, dp=0, en=4'hF:
  - After the next frame_tick, slots show LEDSEL 1110/1101/1011/0111 with the decoded patterns of B/A/2/1.
  - LEDSEL = 1111 on pcnt==0 of each slot.
- Load 16'h5555 then 16'h0007 in consecutive cycles mid-frame → the next frame shows 0007 only; 5555 never appears.
- Load asserted in the same cycle as frame_tick → the following frame shows old data; the frame after shows new data.
- brightness=4'h4 → within any enabled slot, anode is on exactly 4 of every 16 cycles (excluding the gap cycle).
  - brightness=0 → LEDSEL stays 1111.
- SEG_LZB_EN defined, value=16'h0040, dp=4'b1000:
  - Digit 3 shows LEDOUT 8'h7F.
  - Digit 2 is dark.
  - Digits 1 and 0 show 4 and 0.
  - Undefined → all four digits are lit.
- rst driven low mid-frame with a pending load → next cycle LEDSEL = all ones and LEDOUT = 8'hFF. After release, the pending data is not displayed.
